gpsdo_uart_sched: RTL and testbench

- Shares the single UART transmitter between three report sources: phase measurement, PWM duty, and alarm/status.
- Each report is packed into a framed, checksummed byte sequence.
- Bytes are sequenced onto the Uart_En/Uart_Data/Uart_Busy handshake.
- Sits between the phase-detect/PWM control logic and the UART TX block. This replaces the direct one-byte Uart_Data writes.

---
 rtl/gpsdo_uart_sched.sv | 245 ++++++++++++++++++++++++
 tb/tb_gpsdo_uart_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpsdo_uart_sched.sv
// Frames phase/duty/alarm reports and sequences them onto the shared UART TX
// byte handshake, arbitrating round-robin between the three report sources.
module gpsdo_uart_sched #(
    parameter int         BUSY_TIMEOUT = 16,
    parameter logic [7:0] HDR_BYTE     = 8'hA5
) (
    input  logic        CLK_SYS,
    input  logic        CLK_RST,
    input  logic        phase_valid,
    input  logic        phase_order,
    input  logic [31:0] phase_cnt,
    input  logic        duty_valid,
    input  logic [31:0] duty,
    input  logic        alarm_valid,
    input  logic [7:0]  alarm_code,
    input  logic        Uart_Busy,
    output logic        Uart_En,
    output logic [7:0]  Uart_Data,
    output logic        sched_busy,
    output logic [7:0]  drop_cnt
);

    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SEND    = 3'd2,
        S_WAIT_HI = 3'd3,
        S_WAIT_LO = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [2:0]    r_pend;
    logic          r_ph_order;
    logic [31:0]   r_ph_cnt;
    logic [31:0]   r_du_val;
    logic [7:0]    r_al_code;
    logic [1:0]    r_last;
    logic [7:0]    r_drop;
    logic [7:0]    r_buf [0:7];
    logic [3:0]    r_len;
    logic [2:0]    r_idx;
    logic [TW-1:0] r_to;
    logic          r_uart_en;
    logic [7:0]    r_uart_data;

    logic [2:0]    w_valid;
    logic [3:0]    w_pend4;
    logic [1:0]    w_c0;
    logic [1:0]    w_c1;
    logic [1:0]    w_c2;
    logic          w_gnt_any;
    logic [1:0]    w_gnt_src;
    logic [2:0]    w_gnt;
    logic [2:0]    w_drop;
    logic [1:0]    w_drop_inc;
    logic [8:0]    w_drop_sum;
    logic [7:0]    w_fill [0:7];
    logic [3:0]    w_fill_len;
    logic [7:0]    w_chk;
    logic [2:0]    w_last_idx;
    logic          w_is_last;
    logic          w_send;

    function automatic logic [1:0] rr_next(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    assign w_valid = {alarm_valid, duty_valid, phase_valid};
    assign w_pend4 = {1'b0, r_pend};
    assign w_c0    = rr_next(r_last, 2'd1);
    assign w_c1    = rr_next(r_last, 2'd2);
    assign w_c2    = r_last;

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_src = 2'd0;
        if (r_state == S_IDLE) begin
            if (w_pend4[w_c0]) begin
                w_gnt_any = 1'b1;
                w_gnt_src = w_c0;
            end else if (w_pend4[w_c1]) begin
                w_gnt_any = 1'b1;
                w_gnt_src = w_c1;
            end else if (w_pend4[w_c2]) begin
                w_gnt_any = 1'b1;
                w_gnt_src = w_c2;
            end
        end
    end

    // A strobe landing on the grant cycle re-arms pending and is not a drop.
    assign w_gnt      = w_gnt_any ? (3'b001 << w_gnt_src) : 3'b000;
    assign w_drop     = w_valid & r_pend & ~w_gnt;
    assign w_drop_inc = {1'b0, w_drop[0]} + {1'b0, w_drop[1]} + {1'b0, w_drop[2]};
    assign w_drop_sum = {1'b0, r_drop} + {7'b0, w_drop_inc};

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_fill[k] = 8'h00;
        end
        w_fill[0]  = HDR_BYTE;
        w_fill_len = 4'd4;
        case (w_gnt_src)
            2'd0: begin
                w_fill[1]  = 8'h01;
                w_fill[2]  = {7'b0, r_ph_order};
                w_fill[3]  = r_ph_cnt[31:24];
                w_fill[4]  = r_ph_cnt[23:16];
                w_fill[5]  = r_ph_cnt[15:8];
                w_fill[6]  = r_ph_cnt[7:0];
                w_fill_len = 4'd8;
            end
            2'd1: begin
                w_fill[1]  = 8'h02;
                w_fill[2]  = r_du_val[31:24];
                w_fill[3]  = r_du_val[23:16];
                w_fill[4]  = r_du_val[15:8];
                w_fill[5]  = r_du_val[7:0];
                w_fill_len = 4'd7;
            end
            default: begin
                w_fill[1]  = 8'h03;
                w_fill[2]  = r_al_code;
                w_fill_len = 4'd4;
            end
        endcase
    end

    // Unused tail bytes (including the checksum slot) are zero after the snapshot,
    // so XOR over bytes 1..7 yields the checksum for every frame length.
    always_comb begin
        w_chk = 8'h00;
        for (int k = 1; k < 8; k++) begin
            w_chk = w_chk ^ r_buf[k];
        end
    end

    assign w_last_idx = 3'(r_len - 4'd1);
    assign w_is_last  = (r_idx == w_last_idx);
    assign w_send     = (r_state == S_SEND) && !Uart_Busy;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_gnt_any) w_state_next = S_LOAD;
            S_LOAD:    w_state_next = S_SEND;
            S_SEND:    if (!Uart_Busy) w_state_next = S_WAIT_HI;
            S_WAIT_HI: if (Uart_Busy || (r_to == TO_LAST)) w_state_next = S_WAIT_LO;
            S_WAIT_LO: if (!Uart_Busy) w_state_next = w_is_last ? S_IDLE : S_SEND;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            r_pend     <= 3'b000;
            r_ph_order <= 1'b0;
            r_ph_cnt   <= 32'd0;
            r_du_val   <= 32'd0;
            r_al_code  <= 8'd0;
            r_drop     <= 8'd0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (w_valid[k]) begin
                    r_pend[k] <= 1'b1;
                end else if (w_gnt[k]) begin
                    r_pend[k] <= 1'b0;
                end
            end
            if (phase_valid) begin
                r_ph_order <= phase_order;
                r_ph_cnt   <= phase_cnt;
            end
            if (duty_valid) begin
                r_du_val <= duty;
            end
            if (alarm_valid) begin
                r_al_code <= alarm_code;
            end
            r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
        if (!CLK_RST) begin
            for (int k = 0; k < 8; k++) begin
                r_buf[k] <= 8'h00;
            end
            r_len       <= 4'd0;
            r_last      <= 2'd2;
            r_idx       <= 3'd0;
            r_to        <= '0;
            r_uart_en   <= 1'b0;
            r_uart_data <= 8'h00;
        end else begin
            if (w_gnt_any) begin
                for (int k = 0; k < 8; k++) begin
                    r_buf[k] <= w_fill[k];
                end
                r_len  <= w_fill_len;
                r_last <= w_gnt_src;
            end else if (r_state == S_LOAD) begin
                r_buf[w_last_idx] <= w_chk;
            end

            if (r_state == S_IDLE) begin
                r_idx <= 3'd0;
            end else if ((r_state == S_WAIT_LO) && !Uart_Busy && !w_is_last) begin
                r_idx <= r_idx + 3'd1;
            end

            if ((r_state == S_WAIT_HI) && !Uart_Busy && (r_to != TO_LAST)) begin
                r_to <= r_to + 1'b1;
            end else begin
                r_to <= '0;
            end

            r_uart_en <= w_send;
            if (w_send) begin
                r_uart_data <= r_buf[r_idx];
            end
        end
    end

    assign Uart_En    = r_uart_en;
    assign Uart_Data  = r_uart_data;
    assign sched_busy = (r_state != S_IDLE);
    assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_gpsdo_uart_sched.sv
// Bench for gpsdo_uart_sched: directed scenarios plus randomized reports, each
// compared against a frame/round-robin reference model and a small UART model.
module tb_gpsdo_uart_sched;

    localparam int BUSY_TIMEOUT = 16;

    logic        CLK_SYS;
    logic        CLK_RST;
    logic        phase_valid;
    logic        phase_order;
    logic [31:0] phase_cnt;
    logic        duty_valid;
    logic [31:0] duty;
    logic        alarm_valid;
    logic [7:0]  alarm_code;
    logic        Uart_Busy;
    logic        Uart_En;
    logic [7:0]  Uart_Data;
    logic        sched_busy;
    logic [7:0]  drop_cnt;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          uart_mode = 0;
    logic        force_busy = 1'b0;
    int          m_last = 2;
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          en_cyc_q [$];

    gpsdo_uart_sched #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .HDR_BYTE     (8'hA5)
    ) dut (
        .CLK_SYS     (CLK_SYS),
        .CLK_RST     (CLK_RST),
        .phase_valid (phase_valid),
        .phase_order (phase_order),
        .phase_cnt   (phase_cnt),
        .duty_valid  (duty_valid),
        .duty        (duty),
        .alarm_valid (alarm_valid),
        .alarm_code  (alarm_code),
        .Uart_Busy   (Uart_Busy),
        .Uart_En     (Uart_En),
        .Uart_Data   (Uart_Data),
        .sched_busy  (sched_busy),
        .drop_cnt    (drop_cnt)
    );

    initial begin
        CLK_SYS = 1'b0;
        forever #5 CLK_SYS = ~CLK_SYS;
    end

    initial begin
        forever begin
            @(posedge CLK_SYS);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART model: mode 0 raises busy 2 cycles after En for 10 cycles, mode 1 never does.
    initial begin
        int since;
        since = 1000;
        Uart_Busy = 1'b0;
        forever begin
            @(negedge CLK_SYS);
            if (Uart_En === 1'b1) since = 0;
            else if (since < 1000) since++;
            Uart_Busy = force_busy || ((uart_mode == 0) && (since >= 2) && (since < 12));
        end
    end

    // Byte monitor; every strobe must be a single-cycle pulse.
    initial begin
        logic prev_en;
        prev_en = 1'b0;
        forever begin
            @(negedge CLK_SYS);
            if (Uart_En === 1'b1) begin
                check("en_single_cycle", 32'(prev_en), 32'd0);
                got_q.push_back(Uart_Data);
                en_cyc_q.push_back(cyc);
            end
            prev_en = Uart_En;
        end
    end

    task automatic exp_frame(input logic [7:0] typ, input logic [7:0] pl [$]);
        logic [7:0] chk;
        chk = typ;
        exp_q.push_back(8'hA5);
        exp_q.push_back(typ);
        foreach (pl[k]) begin
            exp_q.push_back(pl[k]);
            chk = chk ^ pl[k];
        end
        exp_q.push_back(chk);
    endtask

    task automatic exp_report(input int src, input logic o, input logic [31:0] c,
                              input logic [31:0] d, input logic [7:0] a);
        logic [7:0] pl [$];
        pl = {};
        if (src == 0) begin
            pl.push_back({7'b0, o});
            for (int s = 24; s >= 0; s -= 8) pl.push_back(8'((c >> s) & 32'hFF));
            exp_frame(8'h01, pl);
        end else if (src == 1) begin
            for (int s = 24; s >= 0; s -= 8) pl.push_back(8'((d >> s) & 32'hFF));
            exp_frame(8'h02, pl);
        end else begin
            pl.push_back(a);
            exp_frame(8'h03, pl);
        end
    endtask

    // Reports pending together are served in rotation starting after the last served source.
    task automatic serve(input logic [2:0] mask, input logic o, input logic [31:0] c,
                         input logic [31:0] d, input logic [7:0] a);
        int base;
        base = m_last;
        for (int k = 1; k <= 3; k++) begin
            int s;
            s = (base + k) % 3;
            if (mask[s]) begin
                exp_report(s, o, c, d, a);
                m_last = s;
            end
        end
    endtask

    task automatic strobe(input logic [2:0] mask, input logic o, input logic [31:0] c,
                          input logic [31:0] d, input logic [7:0] a);
        @(posedge CLK_SYS);
        #1;
        phase_valid = mask[0];
        phase_order = o;
        phase_cnt   = c;
        duty_valid  = mask[1];
        duty        = d;
        alarm_valid = mask[2];
        alarm_code  = a;
        @(posedge CLK_SYS);
        #1;
        phase_valid = 1'b0;
        duty_valid  = 1'b0;
        alarm_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK_SYS);
        CLK_RST = 1'b0;
        #2;
        check({tag, "_en"},    32'(Uart_En),    32'd0);
        check({tag, "_data"},  32'(Uart_Data),  32'd0);
        check({tag, "_busy"},  32'(sched_busy), 32'd0);
        check({tag, "_drop"},  32'(drop_cnt),   32'd0);
        repeat (2) @(negedge CLK_SYS);
        CLK_RST = 1'b1;
        m_last = 2;
        got_q.delete();
        en_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_bytes(input int n);
        int w;
        w = 0;
        while (got_q.size() < n && w < 3000) begin
            @(negedge CLK_SYS);
            w++;
        end
    endtask

    task automatic drain(input string tag);
        wait_bytes(exp_q.size());
        repeat (40) @(negedge CLK_SYS);
        check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check({tag, "_idle"}, 32'(sched_busy), 32'd0);
        got_q.delete();
        en_cyc_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic        o;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [7:0]  a;
        logic [2:0]  mask;
        logic [7:0]  last_b;
        int          w;

        CLK_RST     = 1'b0;
        phase_valid = 1'b0;
        phase_order = 1'b0;
        phase_cnt   = 32'd0;
        duty_valid  = 1'b0;
        duty        = 32'd0;
        alarm_valid = 1'b0;
        alarm_code  = 8'd0;

        do_reset("rst0");

        // Single phase report with known checksum 0x26.
        strobe(3'b001, 1'b1, 32'h0000_1234, 32'd0, 8'd0);
        serve(3'b001, 1'b1, 32'h0000_1234, 32'd0, 8'd0);
        repeat (2) @(negedge CLK_SYS);
        check("t1_sched_busy", 32'(sched_busy), 32'd1);
        wait_bytes(8);
        last_b = (got_q.size() >= 8) ? got_q[7] : 8'h00;
        check("t1_chk", 32'(last_b), 32'h26);
        drain("t1");

        // All three sources at once from reset: phase, duty, alarm.
        do_reset("rst1");
        o = 1'($urandom);
        c = $urandom;
        strobe(3'b111, o, c, 32'h0000_84C8, 8'h09);
        serve(3'b111, o, c, 32'h0000_84C8, 8'h09);
        drain("t2");

        // Three duty strobes during a phase frame: two drops, latest value sent.
        do_reset("rst2");
        o  = 1'($urandom);
        c  = $urandom;
        d1 = $urandom;
        d2 = $urandom;
        d  = $urandom;
        strobe(3'b001, o, c, 32'd0, 8'd0);
        serve(3'b001, o, c, 32'd0, 8'd0);
        w = 0;
        while (!sched_busy && w < 20) begin
            @(negedge CLK_SYS);
            w++;
        end
        strobe(3'b010, o, c, d1, 8'd0);
        repeat (2) @(posedge CLK_SYS);
        strobe(3'b010, o, c, d2, 8'd0);
        repeat (2) @(posedge CLK_SYS);
        strobe(3'b010, o, c, d, 8'd0);
        check("t3_drop_cnt", 32'(drop_cnt), 32'd2);
        serve(3'b010, o, c, d, 8'd0);
        drain("t3");

        // UART never busy: index advances BUSY_TIMEOUT+1 after each En, and the
        // next registered strobe follows one cycle later.
        uart_mode = 1;
        a = 8'($urandom);
        strobe(3'b100, 1'b0, 32'd0, 32'd0, a);
        serve(3'b100, 1'b0, 32'd0, 32'd0, a);
        wait_bytes(4);
        for (int i = 1; i < 4; i++) begin
            w = (en_cyc_q.size() > i) ? (en_cyc_q[i] - en_cyc_q[i-1]) : 0;
            check($sformatf("t4_gap%0d", i), 32'(w), 32'(BUSY_TIMEOUT + 2));
        end
        drain("t4");
        uart_mode = 0;

        // Busy held high entering SEND: no strobe until it drops.
        force_busy = 1'b1;
        a = 8'($urandom);
        strobe(3'b100, 1'b0, 32'd0, 32'd0, a);
        repeat (20) @(negedge CLK_SYS);
        check("t5_no_en", 32'(got_q.size()), 32'd0);
        check("t5_sched_busy", 32'(sched_busy), 32'd1);
        force_busy = 1'b0;
        serve(3'b100, 1'b0, 32'd0, 32'd0, a);
        drain("t5");

        // Reset after byte 3 of a duty frame abandons it; a new alarm frame completes.
        check("t6_drop_pre", 32'(drop_cnt), 32'd2);
        d = $urandom;
        strobe(3'b010, 1'b0, 32'd0, d, 8'd0);
        wait_bytes(3);
        do_reset("t6_rst");
        a = 8'($urandom);
        strobe(3'b100, 1'b0, 32'd0, 32'd0, a);
        serve(3'b100, 1'b0, 32'd0, 32'd0, a);
        drain("t6");

        // Randomized report mixes and UART behaviour.
        for (int it = 0; it < 10; it++) begin
            uart_mode = int'($urandom_range(0, 1));
            mask = 3'($urandom_range(1, 7));
            o = 1'($urandom);
            c = $urandom;
            d = $urandom;
            a = 8'($urandom);
            strobe(mask, o, c, d, a);
            serve(mask, o, c, d, a);
            drain($sformatf("rnd%0d", it));
        end
        uart_mode = 0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
